uart_frame_engine: RTL and testbench

Parametrised full-duplex UART frame engine, successor to the fixed 8E1 echo UART in the LAB designs. It has:
- independent RX and TX paths with configurable data width, parity mode and stop bits;
- 3-sample majority-vote oversampled reception feeding a small RX FIFO with per-word error flags;
- a valid/ready TX interface with an RS485 driver-enable guard interval.

It sits between the board pins and user logic such as display or command decoders.

---
 rtl/uart_frame_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_frame_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_engine.sv
// Full-duplex UART frame engine: majority-voted oversampled RX into a small
// flagged FIFO, and a valid/ready TX path with an RS485 driver-enable guard.
module uart_frame_engine #(
    parameter int unsigned CLK_FREQ   = 1843200,
    parameter int unsigned BAUD_RATE  = 57600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 2,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned GUARD_BITS = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    output logic                 de,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);
    localparam int unsigned DIV      = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned BIT_CLKS = DIV * OVERSAMPLE;
    localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W    = $clog2(BIT_CLKS);
    localparam int unsigned OS_W     = $clog2(OVERSAMPLE);
    localparam int unsigned RB_W     = $clog2(DATA_BITS);
    localparam int unsigned TB_W     = 8;
    localparam int unsigned WORD_W   = DATA_BITS + 2;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic        PAR_ODD  = (PARITY == 1);
    localparam logic [OS_W-1:0] VOTE_A = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] VOTE_B = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] VOTE_C = OS_W'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_GUARD, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

    rx_state_e             rx_state_q, rx_state_d;
    tx_state_e             tx_state_q, tx_state_d;
    logic                  rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d, os_next;
    logic [1:0]            vote_q, vote_d;
    logic [RB_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  par_err_q, par_err_d, push_q, push_d;
    logic [WORD_W-1:0]     rx_word_q, rx_word_d;
    logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FC_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [WORD_W-1:0]     head_q, head_d;
    logic                  rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [TB_W-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d, tx_q, tx_d, de_q, de_d, tx_ready_q, tx_ready_d;
    logic                  tick, voted, pop, full, do_push, accept, bit_end;

    // Synchronizer, sample-tick divider and RX bit FSM
    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        tick       = (div_q == DIV_W'(DIV - 1));
        div_d      = tick ? '0 : div_q + 1'b1;
        rx_state_d = rx_state_q;
        os_cnt_d   = os_cnt_q;
        vote_d     = vote_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        par_err_d  = par_err_q;
        rx_word_d  = rx_word_q;
        push_d     = 1'b0;
        os_next    = (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;
        voted      = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_sync_q) | (vote_q[0] & rx_sync_q);
        if (tick) begin
            if (rx_state_q == RX_IDLE) begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    os_cnt_d   = '0;
                    rx_bit_d   = '0;
                    par_err_d  = 1'b0;
                end
            end else begin
                os_cnt_d = os_next;
                if (os_next == VOTE_A || os_next == VOTE_B) vote_d = {vote_q[0], rx_sync_q};
                // Third sample completes the vote; act on the bit now (mid-bit)
                if (os_next == VOTE_C) begin
                    case (rx_state_q)
                        RX_START: rx_state_d = voted ? RX_IDLE : RX_DATA;
                        RX_DATA: begin
                            rx_shift_d = {voted, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bit_q == RB_W'(DATA_BITS - 1)) begin
                                rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_d = rx_bit_q + 1'b1;
                            end
                        end
                        RX_PARITY: begin
                            par_err_d  = voted ^ (^rx_shift_q) ^ PAR_ODD;
                            rx_state_d = RX_STOP;
                        end
                        RX_STOP: begin
                            rx_word_d  = {~voted, par_err_q, rx_shift_q};
                            push_d     = 1'b1;
                            rx_state_d = RX_IDLE;
                        end
                        default: rx_state_d = RX_IDLE;
                    endcase
                end
            end
        end
    end

    // RX FIFO with registered head word; a pop frees room for a same-cycle push
    always_comb begin
        pop        = rx_ready && rx_valid_q;
        full       = (fifo_cnt_q == FC_W'(FIFO_DEPTH));
        do_push    = push_q && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        overrun_d  = overrun_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = rx_word_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (pop && !do_push) fifo_cnt_d = fifo_cnt_q - 1'b1;
        if (pop) overrun_d = 1'b0;
        else if (push_q && full) overrun_d = 1'b1;
        head_d     = mem_d[rd_ptr_d];
        rx_valid_d = (fifo_cnt_d != '0);
    end

    // TX FSM; line outputs follow the state by one cycle
    always_comb begin
        accept     = tx_valid && tx_ready_q;
        bit_end    = (tx_cnt_q == CNT_W'(BIT_CLKS - 1));
        tx_state_d = tx_state_q;
        tx_cnt_d   = bit_end ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (accept) begin
                    tx_state_d = (GUARD_BITS != 0) ? TX_GUARD : TX_START;
                    tx_bit_d   = '0;
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                end
            end
            TX_GUARD: if (bit_end) begin
                if (tx_bit_q == TB_W'(GUARD_BITS - 1)) begin
                    tx_state_d = TX_START;
                    tx_bit_d   = '0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            TX_START: if (bit_end) tx_state_d = TX_DATA;
            TX_DATA: if (bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == TB_W'(DATA_BITS - 1)) begin
                    tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
                    tx_bit_d   = '0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            TX_PARITY: if (bit_end) tx_state_d = TX_STOP;
            TX_STOP: if (bit_end) begin
                if (tx_bit_q == TB_W'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
                else tx_bit_d = tx_bit_q + 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_q)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_q[0];
            TX_PARITY: tx_d = tx_par_q;
            default:   tx_d = 1'b1;
        endcase
        de_d       = (tx_state_q != TX_IDLE) || accept;
        tx_ready_d = (tx_state_q == TX_IDLE) && !accept;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            div_q      <= '0;
            rx_state_q <= RX_IDLE;
            os_cnt_q   <= '0;
            vote_q     <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            par_err_q  <= 1'b0;
            rx_word_q  <= '0;
            push_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            head_q     <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            de_q       <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            div_q      <= div_d;
            rx_state_q <= rx_state_d;
            os_cnt_q   <= os_cnt_d;
            vote_q     <= vote_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            par_err_q  <= par_err_d;
            rx_word_q  <= rx_word_d;
            push_q     <= push_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            head_q     <= head_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            de_q       <= de_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx            = tx_q;
    assign de            = de_q;
    assign tx_ready      = tx_ready_q;
    assign rx_data       = head_q[DATA_BITS-1:0];
    assign rx_parity_err = head_q[DATA_BITS];
    assign rx_frame_err  = head_q[DATA_BITS+1];
    assign rx_valid      = rx_valid_q;
    assign rx_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_frame_engine.sv
// Directed bench for uart_frame_engine at default parameters (8E1, 32 clocks per bit, 2 guard bits).
module tb_uart_frame_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       tx, de, tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;
    logic       rx_parity_err, rx_frame_err, rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    int         errors = 0;
    int         checks = 0;

    uart_frame_engine dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .de(de),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept at cycle 0, then compare tx every cycle to the hand-built 8E1 frame
    task automatic tx_frame(input logic [7:0] d);
        logic [10:0] bits;
        logic        exp_tx;
        bits = {1'b1, ^d, d, 1'b0};
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("tx_de_c0", de, 1);
        check("tx_ready_c0", tx_ready, 0);
        check("tx_line_c0", tx, 1);
        for (int k = 1; k <= 417; k++) begin
            @(posedge clk); #1;
            exp_tx = (k < 65 || k >= 417) ? 1'b1 : bits[(k - 65) / 32];
            check($sformatf("tx_line_c%0d", k), tx, exp_tx);
            if (k == 416) begin
                check("tx_ready_c416", tx_ready, 0);
                check("tx_de_c416", de, 1);
            end
            if (k == 417) begin
                check("tx_ready_c417", tx_ready, 1);
                check("tx_de_c417", de, 0);
            end
        end
    endtask

    task automatic rx_bit(input logic b);
        rx = b;
        repeat (32) @(negedge clk);
    endtask

    // Drive one 8E1 frame, optionally corrupting parity and/or stop
    task automatic rx_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
        @(negedge clk);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        rx_bit((^d) ^ par_flip);
        rx_bit(stop_bit);
        rx = 1'b1;
        repeat (48) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_de", de, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_overrun", rx_overrun, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        tx_frame(8'hA5);

        rx_frame(8'h3C, 1'b0, 1'b1);
        check("rx_ok_valid", rx_valid, 1);
        check("rx_ok_data", rx_data, 8'h3C);
        check("rx_ok_perr", rx_parity_err, 0);
        check("rx_ok_ferr", rx_frame_err, 0);
        pop();
        check("rx_ok_popped", rx_valid, 0);

        rx_frame(8'h3C, 1'b1, 1'b1);
        check("rx_perr_valid", rx_valid, 1);
        check("rx_perr_data", rx_data, 8'h3C);
        check("rx_perr_perr", rx_parity_err, 1);
        check("rx_perr_ferr", rx_frame_err, 0);
        pop();

        rx_frame(8'h3C, 1'b0, 1'b0);
        check("rx_ferr_valid", rx_valid, 1);
        check("rx_ferr_data", rx_data, 8'h3C);
        check("rx_ferr_perr", rx_parity_err, 0);
        check("rx_ferr_ferr", rx_frame_err, 1);
        pop();
        check("rx_ferr_popped", rx_valid, 0);
        repeat (64) @(negedge clk);

        // Glitch of 8 clocks (4 ticks) must be rejected as a false start
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_no_push", rx_valid, 0);
        rx_frame(8'h55, 1'b0, 1'b1);
        check("glitch_next_valid", rx_valid, 1);
        check("glitch_next_data", rx_data, 8'h55);
        check("glitch_next_perr", rx_parity_err, 0);
        check("glitch_next_ferr", rx_frame_err, 0);
        pop();

        for (int f = 1; f <= 5; f++) rx_frame(8'(f), 1'b0, 1'b1);
        check("ovr_flag", rx_overrun, 1);
        check("ovr_valid", rx_valid, 1);
        check("ovr_head1", rx_data, 8'h01);
        pop();
        check("ovr_cleared", rx_overrun, 0);
        check("ovr_head2", rx_data, 8'h02);
        pop();
        check("ovr_head3", rx_data, 8'h03);
        pop();
        check("ovr_head4", rx_data, 8'h04);
        check("ovr_valid4", rx_valid, 1);
        pop();
        check("ovr_empty", rx_valid, 0);
        pop();
        check("ovr_empty_pop", rx_valid, 0);
        check("ovr_empty_flag", rx_overrun, 0);

        // Reset during data bit 3 (cycle 209 after accept)
        @(negedge clk);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (209) @(posedge clk);
        #1;
        check("midrst_de_before", de, 1);
        check("midrst_ready_before", tx_ready, 0);
        reset = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_de", de, 0);
        check("midrst_ready", tx_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        tx_frame(8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
